// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the sequential Booth multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package booth_pkg;

    // Controller states: waiting for operands, iterating, holding the product.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Radix-4 partial-product selection decoded from {Q[1],Q[0],Q[-1]}.
    typedef enum logic [2:0] {
        ZERO = 3'd0,   // add nothing
        PM1  = 3'd1,   // +M
        PP2  = 3'd2,   // +2M
        NM1  = 3'd3,   // -M
        NM2  = 3'd4    // -2M
    } recode_e;

    // Number of RUN cycles: one per multiplier bit of the widened operand
    // (radix-2) or one per bit pair, rounded up (radix-4).
    function automatic int booth_iters(input int width, input int radix);
        return (radix == 4) ? (width + 2) / 2 : width + 1;
    endfunction

    // Accumulator width: widened operand plus one guard bit (radix-2) or
    // two guard bits (radix-4, where +/-2M is possible).
    function automatic int booth_a_bits(input int width, input int radix);
        return width + 1 + radix / 2;
    endfunction

    // Multiplier bits held in Q (excluding Q[-1]). Radix-4 rounds the widened
    // operand up to an even count so the last bit pair is complete; the extra
    // bit is a copy of the operand sign.
    function automatic int booth_q_bits(input int width, input int radix);
        return (radix == 4) ? 2 * ((width + 2) / 2) : width + 1;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: recode, add/subtract M, arithmetic shift of {A,Q}.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int RADIX = 2,
    parameter int AW    = booth_a_bits(WIDTH, RADIX),
    parameter int QW    = booth_q_bits(WIDTH, RADIX)
) (
    input  logic [AW-1:0]  i_a,
    input  logic [QW:0]    i_q,   // bit 0 is Q[-1]
    input  logic [WIDTH:0] i_m,   // already sign/zero extended to WIDTH+1
    output logic [AW-1:0]  o_a,
    output logic [QW:0]    o_q
);

    localparam int W1 = WIDTH + 1;

    logic [AW-1:0] w_m_ext;
    logic [AW-1:0] w_addend;
    logic [AW-1:0] w_sum;
    logic          w_cin;

    // M is a signed W1-bit value in both modes, so widen it by sign extension.
    assign w_m_ext = {{(AW-W1){i_m[W1-1]}}, i_m};

    // Subtraction is formed as A + ~X + 1 so a single adder covers every case.
    assign w_sum = i_a + w_addend + {{(AW-1){1'b0}}, w_cin};

    generate
        if (RADIX == 4) begin : g_r4
            recode_e w_code;

            // Recode the overlapping bit triplet into a partial-product selector.
            always_comb begin
                w_code = ZERO;
                case (i_q[2:0])
                    3'b001, 3'b010: w_code = PM1;
                    3'b011:         w_code = PP2;
                    3'b100:         w_code = NM2;
                    3'b101, 3'b110: w_code = NM1;
                    default:        w_code = ZERO;
                endcase
            end

            // Choose the addend; 2M is M shifted left, which the second guard bit absorbs.
            always_comb begin
                w_addend = '0;
                w_cin    = 1'b0;
                case (w_code)
                    PM1: w_addend = w_m_ext;
                    PP2: w_addend = {w_m_ext[AW-2:0], 1'b0};
                    NM1: begin
                        w_addend = ~w_m_ext;
                        w_cin    = 1'b1;
                    end
                    NM2: begin
                        w_addend = ~{w_m_ext[AW-2:0], 1'b0};
                        w_cin    = 1'b1;
                    end
                    default: begin
                        w_addend = '0;
                        w_cin    = 1'b0;
                    end
                endcase
            end

            // Arithmetic shift right by two across {A,Q}.
            assign o_a = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
            assign o_q = {w_sum[1:0], i_q[QW:2]};
        end else begin : g_r2
            // Radix-2 decode of {Q[0],Q[-1]}: 01 adds M, 10 subtracts M.
            always_comb begin
                w_addend = '0;
                w_cin    = 1'b0;
                case (i_q[1:0])
                    2'b01: w_addend = w_m_ext;
                    2'b10: begin
                        w_addend = ~w_m_ext;
                        w_cin    = 1'b1;
                    end
                    default: begin
                        w_addend = '0;
                        w_cin    = 1'b0;
                    end
                endcase
            end

            // Arithmetic shift right by one across {A,Q}.
            assign o_a = {w_sum[AW-1], w_sum[AW-1:1]};
            assign o_q = {w_sum[0], i_q[QW:1]};
        end
    endgenerate

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative Booth multiplier (radix-2 or radix-4), signed or unsigned per transaction.
// Latency: out_valid is registered N clocks after the accept edge and is taken by the consumer on edge N+1.
// Backpressure: in_ready only in IDLE; out_ready low holds DONE with product/out_valid stable.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int RADIX = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int W1 = WIDTH + 1;
    localparam int N  = booth_iters(WIDTH, RADIX);
    localparam int AW = booth_a_bits(WIDTH, RADIX);
    localparam int QW = booth_q_bits(WIDTH, RADIX);
    localparam int CW = $clog2(N + 1);

    generate
        if (RADIX != 2 && RADIX != 4) begin : g_bad_radix
            $error("booth_mult_seq: RADIX must be 2 or 4");
        end
        if (WIDTH < 4) begin : g_bad_width
            $error("booth_mult_seq: WIDTH must be at least 4");
        end
    endgenerate

    state_e        r_state;
    state_e        w_state_nxt;

    logic [AW-1:0] r_a;
    logic [QW:0]   r_q;      // bit 0 is Q[-1]
    logic [W1-1:0] r_m;
    logic [CW-1:0] r_cnt;

    logic [W1-1:0] w_m_ext;
    logic [W1-1:0] w_q_ext;
    logic [QW-1:0] w_q_load;
    logic [AW-1:0] w_step_a;
    logic [QW:0]   w_step_q;
    logic          w_accept;
    logic          w_last;

    // Widen both operands by one bit: the sign in signed mode, zero otherwise,
    // so the datapath always treats them as signed W1-bit numbers.
    assign w_m_ext = {in_signed & multiplicand[WIDTH-1], multiplicand};
    assign w_q_ext = {in_signed & multiplier[WIDTH-1], multiplier};

    // Fill any extra Q bits (radix-4 with odd W1) with the operand sign.
    always_comb begin
        w_q_load           = {QW{w_q_ext[W1-1]}};
        w_q_load[W1-1:0]   = w_q_ext;
    end

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == CW'(1));

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: accept in IDLE, iterate N cycles, wait for the consumer in DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = RUN;
            RUN:     if (w_last)   w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded purely from state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Operand load on accept, one Booth step per RUN cycle, hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= '0;
                        r_q   <= {w_q_load, 1'b0};
                        r_m   <= w_m_ext;
                        r_cnt <= CW'(N);
                    end
                end
                RUN: begin
                    r_a   <= w_step_a;
                    r_q   <= w_step_q;
                    r_cnt <= r_cnt - CW'(1);
                end
                default: begin
                    r_a   <= r_a;
                    r_q   <= r_q;
                    r_m   <= r_m;
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    booth_step #(
        .WIDTH (WIDTH),
        .RADIX (RADIX),
        .AW    (AW),
        .QW    (QW)
    ) u_step (
        .i_a (r_a),
        .i_q (r_q),
        .i_m (r_m),
        .o_a (w_step_a),
        .o_q (w_step_q)
    );

    // After N steps {A,Q[QW:1]} holds the full signed product of the widened
    // operands; its low 2*WIDTH bits are the answer in both modes.
    assign product = (2*WIDTH)'({r_a, r_q[QW:1]});

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench: radix-2 and radix-4 instances driven in lockstep, plus standalone step checks.
// Latency: checks the handshake edge at N+1 clocks after accept (26 / 14).
// Backpressure: exercises held DONE, busy in_valid pulses, and mid-RUN reset.
module tb_booth_mult_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_signed;
    logic [23:0] multiplicand;
    logic [23:0] multiplier;
    logic        out_ready;

    logic        in_ready_r2, out_valid_r2;
    logic        in_ready_r4, out_valid_r4;
    logic [47:0] product_r2, product_r4;

    int n_vec = 0;
    int n_bad = 0;

    // Standalone step instances at WIDTH=4.
    logic [5:0] st2_a, st2_q, st2_oa, st2_oq;
    logic [6:0] st4_a, st4_q, st4_oa, st4_oq;
    logic [4:0] st2_m, st4_m;

    booth_mult_seq #(.WIDTH(24), .RADIX(2)) u_r2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r2),
        .in_signed(in_signed), .multiplicand(multiplicand), .multiplier(multiplier),
        .out_valid(out_valid_r2), .out_ready(out_ready), .product(product_r2)
    );

    booth_mult_seq #(.WIDTH(24), .RADIX(4)) u_r4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r4),
        .in_signed(in_signed), .multiplicand(multiplicand), .multiplier(multiplier),
        .out_valid(out_valid_r4), .out_ready(out_ready), .product(product_r4)
    );

    booth_step #(.WIDTH(4), .RADIX(2)) u_st2 (
        .i_a(st2_a), .i_q(st2_q), .i_m(st2_m), .o_a(st2_oa), .o_q(st2_oq)
    );

    booth_step #(.WIDTH(4), .RADIX(4)) u_st4 (
        .i_a(st4_a), .i_q(st4_q), .i_m(st4_m), .o_a(st4_oa), .o_q(st4_oq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge. Accepts one operation on both instances,
    // pokes in_valid while busy, measures the handshake edge, optionally holds
    // DONE for `hold` cycles, then releases with out_ready for one edge.
    task automatic do_op(input string tag, input logic s, input logic [23:0] m,
                         input logic [23:0] q, input logic [47:0] exp, input int hold);
        int n;
        int l2;
        int l4;
        check({tag, "/in_ready_r2"}, 64'(in_ready_r2), 64'd1);
        check({tag, "/in_ready_r4"}, 64'(in_ready_r4), 64'd1);
        in_valid     = 1'b1;
        in_signed    = s;
        multiplicand = m;
        multiplier   = q;
        out_ready    = 1'b0;
        @(posedge clk);
        n  = 0;
        l2 = 0;
        l4 = 0;
        while ((l2 == 0 || l4 == 0) && n < 60) begin
            @(negedge clk);
            if (n == 0) begin
                in_valid     = 1'b0;
                in_signed    = ~s;
                multiplicand = 24'($urandom);
                multiplier   = 24'($urandom);
            end
            if (n == 3) begin
                in_valid = 1'b1;
                check({tag, "/busy_rdy_r2"}, 64'(in_ready_r2), 64'd0);
                check({tag, "/busy_rdy_r4"}, 64'(in_ready_r4), 64'd0);
            end
            if (n == 5) in_valid = 1'b0;
            if (l2 == 0 && out_valid_r2) l2 = n + 1;
            if (l4 == 0 && out_valid_r4) l4 = n + 1;
            @(posedge clk);
            n++;
        end
        check({tag, "/lat_r2"}, 64'(l2), 64'd26);
        check({tag, "/lat_r4"}, 64'(l4), 64'd14);
        @(negedge clk);
        check({tag, "/prod_r2"}, 64'(product_r2), 64'(exp));
        check({tag, "/prod_r4"}, 64'(product_r4), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "/hold_vld_r2"}, 64'(out_valid_r2), 64'd1);
            check({tag, "/hold_vld_r4"}, 64'(out_valid_r4), 64'd1);
            check({tag, "/hold_prod_r2"}, 64'(product_r2), 64'(exp));
            check({tag, "/hold_prod_r4"}, 64'(product_r4), 64'(exp));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "/idle_rdy_r2"}, 64'(in_ready_r2), 64'd1);
        check({tag, "/idle_rdy_r4"}, 64'(in_ready_r4), 64'd1);
        check({tag, "/idle_vld_r2"}, 64'(out_valid_r2), 64'd0);
        check({tag, "/idle_vld_r4"}, 64'(out_valid_r4), 64'd0);
    endtask

    initial begin
        logic [47:0] exp_mix;
        int          stale;
        exp_mix      = 48'(-64'sd9449772114007);
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_signed    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        out_ready    = 1'b0;
        st2_a = '0; st2_q = '0; st2_m = '0;
        st4_a = '0; st4_q = '0; st4_m = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst/in_ready_r2", 64'(in_ready_r2), 64'd1);
        check("rst/in_ready_r4", 64'(in_ready_r4), 64'd1);
        check("rst/out_valid_r2", 64'(out_valid_r2), 64'd0);
        check("rst/out_valid_r4", 64'(out_valid_r4), 64'd0);
        check("rst/product_r2", 64'(product_r2), 64'd0);
        check("rst/product_r4", 64'(product_r4), 64'd0);

        // Single-step golden checks (WIDTH=4, M=5).
        st2_a = 6'b000000; st2_q = 6'b000110; st2_m = 5'b00101;
        #1;
        check("step2/sub_a", 64'(st2_oa), 64'b111101);
        check("step2/sub_q", 64'(st2_oq), 64'b100011);
        st2_a = 6'b000001; st2_q = 6'b000001;
        #1;
        check("step2/add_a", 64'(st2_oa), 64'b000011);
        check("step2/add_q", 64'(st2_oq), 64'b000000);
        st4_a = 7'b0000000; st4_q = 7'b0000110; st4_m = 5'b00101;
        #1;
        check("step4/nm1_a", 64'(st4_oa), 64'b1111110);
        check("step4/nm1_q", 64'(st4_oq), 64'b1100001);
        st4_q = 7'b0000011;
        #1;
        check("step4/pp2_a", 64'(st4_oa), 64'b0000010);
        check("step4/pp2_q", 64'(st4_oq), 64'b1000000);
        st4_a = 7'b0000100; st4_q = 7'b0001000;
        #1;
        check("step4/zero_a", 64'(st4_oa), 64'b0000001);
        check("step4/zero_q", 64'(st4_oq), 64'b0000010);
        st4_a = 7'b0000000; st4_q = 7'b0000100;
        #1;
        check("step4/nm2_a", 64'(st4_oa), 64'b1111101);
        check("step4/nm2_q", 64'(st4_oq), 64'b1000001);

        rst_n = 1'b1;

        // Full transactions.
        do_op("neg1_sq",  1'b1, 24'hFFFFFF, 24'hFFFFFF, 48'h000000000001, 0);
        do_op("smin_sq",  1'b1, 24'h800000, 24'h800000, 48'h400000000000, 0);
        do_op("umax_sq",  1'b0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 0);
        do_op("mixed",    1'b1, 24'd1234567, 24'(-32'sd7654321), exp_mix, 0);
        do_op("bp_u",     1'b0, 24'h800000, 24'h000003, 48'h000001800000, 10);
        do_op("b2b_m0",   1'b1, 24'h000000, 24'h7FFFFF, 48'h000000000000, 0);
        do_op("b2b_q0",   1'b0, 24'h123456, 24'h000000, 48'h000000000000, 0);
        do_op("smax_min", 1'b1, 24'h7FFFFF, 24'h800000, 48'hC00000800000, 0);

        // Reset during RUN cycle 7 discards the operation.
        in_valid     = 1'b1;
        in_signed    = 1'b1;
        multiplicand = 24'hFFFFFF;
        multiplier   = 24'h000005;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst/in_ready_r2", 64'(in_ready_r2), 64'd1);
        check("midrst/in_ready_r4", 64'(in_ready_r4), 64'd1);
        check("midrst/out_valid_r2", 64'(out_valid_r2), 64'd0);
        check("midrst/out_valid_r4", 64'(out_valid_r4), 64'd0);
        check("midrst/product_r2", 64'(product_r2), 64'd0);
        check("midrst/product_r4", 64'(product_r4), 64'd0);
        stale = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid_r2 || out_valid_r4) stale++;
        end
        check("midrst/no_stale", 64'(stale), 64'd0);
        do_op("post_rst", 1'b0, 24'h000123, 24'h000456, 48'h00000004EDC2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
